rom_sample_streamer: RTL and testbench
======================================

ROM_SAMPLE_STREAMER -- requirements
Module: rom_sample_streamer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: width of each sample word (ib, vt, soc).
REQ-002 SHALL have parameter A_WIDTH, default 10: ROM address width.
REQ-003 SHALL have parameter N_SAMPLES, default 1024: samples per run; legal range 1..2**A_WIDTH.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of a running sequence.
REQ-008 SHALL have port raddr, output, A_WIDTH: registered address shared by the ib, vt and soc ROMs.
REQ-009 SHALL have ports ib_in, vt_in and soc_in, input, D_WIDTH each: ROM read data, valid one cycle after raddr.
REQ-010 SHALL have ports ib_out, vt_out and soc_out, output, D_WIDTH each: registered sample to the EKF stage.
REQ-011 SHALL have port out_idx, output, A_WIDTH: ROM address of the sample currently presented.
REQ-012 SHALL have port out_valid, output, 1: sample is presented.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the sample.
REQ-014 SHALL have port out_last, output, 1: presented sample is index N_SAMPLES-1.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the last sample is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT1, WAIT2 and HOLD.
REQ-018 In IDLE with start=1, SHALL load raddr<=0 and go to WAIT1.
REQ-019 SHALL go WAIT1->WAIT2 unconditionally; the ROM registers raddr on this edge.
REQ-020 On the WAIT2 edge, SHALL latch ib_in/vt_in/soc_in into the *_out registers, set out_idx<=raddr, set out_valid<=1 and go to HOLD.
REQ-021 Latency: out_valid SHALL rise exactly 2 cycles after the edge that samples start.
REQ-022 In HOLD with out_ready=0, all outputs SHALL remain stable.
REQ-023 In HOLD with out_ready=1 and raddr!=N_SAMPLES-1, SHALL clear out_valid, set raddr<=raddr+1 and go to WAIT1; throughput is 1 sample per 3 cycles.
REQ-024 In HOLD with out_ready=1 and raddr==N_SAMPLES-1, SHALL clear out_valid, pulse done for exactly one cycle and return to IDLE.
REQ-025 out_last SHALL equal out_valid AND (out_idx==N_SAMPLES-1).
REQ-026 raddr SHALL never exceed N_SAMPLES-1 and SHALL never wrap.
REQ-027 start while busy SHALL be ignored.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 abort=1 in any non-IDLE state SHALL, on the next edge, go to IDLE, clear out_valid and leave done at 0.
REQ-030 abort SHALL take priority over the handshake on the same edge.
REQ-031 abort in IDLE SHALL be ignored, including when start=1 on the same edge; start is blocked.
REQ-032 *_out and out_idx SHALL retain the last latched values after done or abort.
REQ-033 With N_SAMPLES=1, a run SHALL present exactly one sample, with out_last=1.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for clk, force: state IDLE; raddr, out_idx, ib_out, vt_out, soc_out = 0; out_valid, out_last, busy, done = 0.
REQ-035 rst asserted mid-run SHALL discard the run, with no done pulse.
REQ-036 After rst deasserts, the block SHALL require a new start.

Verification
REQ-037 N_SAMPLES=4, ROM ib[k]=k+10, out_ready=1 -> ib_out sequence 10,11,12,13; out_valid pulses spaced 3 cycles apart; done single pulse 1 cycle after sample 3 is accepted; out_last=1 only on idx 3.
REQ-038 Backpressure: out_ready=0 for 5 cycles on idx 2 -> ib_out, vt_out, soc_out and out_idx stable for all 5 cycles; idx 3 follows 3 cycles after ready rises.
REQ-039 start pulsed again while busy at idx 1 -> no restart; raddr continues to 2; exactly one done pulse.
REQ-040 abort asserted during HOLD at idx 2 with out_ready=1 -> IDLE next cycle; out_valid=0; done never pulses; new start restarts at raddr=0.
REQ-041 rst asserted asynchronously between edges during WAIT2 -> all outputs 0 before the next clk edge; done stays 0.
REQ-042 N_SAMPLES=1 -> one sample with out_idx=0 and out_last=1; done pulses; raddr stays 0.

Source files
------------

// File: rtl/rom_sample_streamer.sv
// rom_sample_streamer: walks a shared ROM address from 0 to N_SAMPLES-1 and
// presents each (ib, vt, soc) triple to the EKF stage with a valid/ready
// handshake. Each sample costs three cycles: address issue, ROM access, and
// capture/present.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, abort                  run request (IDLE only), cancel of a running sequence
//   raddr                         registered ROM address shared by all three ROMs
//   ib_in, vt_in, soc_in          ROM read data, valid one cycle after raddr
//   ib_out, vt_out, soc_out       registered sample
//   out_idx                       ROM address of the presented sample
//   out_valid, out_ready          presentation handshake
//   out_last                      presented sample is the final index
//   busy                          state is not IDLE
//   done                          one-cycle pulse after the final sample is accepted
module rom_sample_streamer #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned A_WIDTH   = 10,
  parameter int unsigned N_SAMPLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [D_WIDTH-1:0] ib_in,
  input  logic [D_WIDTH-1:0] vt_in,
  input  logic [D_WIDTH-1:0] soc_in,
  output logic [D_WIDTH-1:0] ib_out,
  output logic [D_WIDTH-1:0] vt_out,
  output logic [D_WIDTH-1:0] soc_out,
  output logic [A_WIDTH-1:0] out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, HOLD} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] raddr_nxt, out_idx_nxt;
  logic [D_WIDTH-1:0] ib_nxt, vt_nxt, soc_nxt;
  logic               valid_nxt, last_nxt, busy_nxt, done_nxt;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      raddr     <= '0;
      out_idx   <= '0;
      ib_out    <= '0;
      vt_out    <= '0;
      soc_out   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      raddr     <= raddr_nxt;
      out_idx   <= out_idx_nxt;
      ib_out    <= ib_nxt;
      vt_out    <= vt_nxt;
      soc_out   <= soc_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    raddr_nxt   = raddr;
    out_idx_nxt = out_idx;
    ib_nxt      = ib_out;
    vt_nxt      = vt_out;
    soc_nxt     = soc_out;
    valid_nxt   = out_valid;
    done_nxt    = 1'b0;

    if (state != IDLE && abort) begin
      // Cancel wins over any handshake; captured data is kept for inspection
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // An abort in IDLE does nothing itself but blocks a coincident start
          if (start && !abort) begin
            raddr_nxt = '0;
            state_nxt = WAIT1;
          end
        end
        WAIT1: state_nxt = WAIT2;
        WAIT2: begin
          ib_nxt      = ib_in;
          vt_nxt      = vt_in;
          soc_nxt     = soc_in;
          out_idx_nxt = raddr;
          valid_nxt   = 1'b1;
          state_nxt   = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            valid_nxt = 1'b0;
            if (raddr == LAST_IDX) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              raddr_nxt = raddr + A_WIDTH'(1);
              state_nxt = WAIT1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    last_nxt = valid_nxt && (out_idx_nxt == LAST_IDX);
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_rom_sample_streamer.sv
// Directed bench for rom_sample_streamer: a 4-sample instance covering normal
// streaming, backpressure, start-while-busy, abort and async reset, plus a
// 1-sample instance. ROM contents: ib[k]=k+10, vt[k]=k+20, soc[k]=k+30.
module tb_rom_sample_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          start, abort, out_ready;
  logic [AW-1:0] raddr, out_idx;
  logic [DW-1:0] ib_in, vt_in, soc_in, ib_out, vt_out, soc_out;
  logic          out_valid, out_last, busy, done;

  logic          start1, abort1, out_ready1;
  logic [AW-1:0] raddr1, out_idx1;
  logic [DW-1:0] ib_in1, vt_in1, soc_in1, ib_out1, vt_out1, soc_out1;
  logic          out_valid1, out_last1, busy1, done1;

  int tests = 0;
  int fails = 0;

  rom_sample_streamer #(.D_WIDTH(DW), .A_WIDTH(AW), .N_SAMPLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .raddr(raddr),
    .ib_in(ib_in), .vt_in(vt_in), .soc_in(soc_in),
    .ib_out(ib_out), .vt_out(vt_out), .soc_out(soc_out),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  rom_sample_streamer #(.D_WIDTH(DW), .A_WIDTH(AW), .N_SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .raddr(raddr1),
    .ib_in(ib_in1), .vt_in(vt_in1), .soc_in(soc_in1),
    .ib_out(ib_out1), .vt_out(vt_out1), .soc_out(soc_out1),
    .out_idx(out_idx1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM models: data valid one cycle after the address
  always_ff @(posedge clk) begin
    ib_in   <= 32'(raddr) + 32'd10;
    vt_in   <= 32'(raddr) + 32'd20;
    soc_in  <= 32'(raddr) + 32'd30;
    ib_in1  <= 32'(raddr1) + 32'd10;
    vt_in1  <= 32'(raddr1) + 32'd20;
    soc_in1 <= 32'(raddr1) + 32'd30;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_sample(input int k, input int last_k);
    chk($sformatf("valid[%0d]", k), 32'(out_valid), 32'd1);
    chk($sformatf("ib[%0d]", k),    ib_out,  32'(k + 10));
    chk($sformatf("vt[%0d]", k),    vt_out,  32'(k + 20));
    chk($sformatf("soc[%0d]", k),   soc_out, 32'(k + 30));
    chk($sformatf("idx[%0d]", k),   32'(out_idx), 32'(k));
    chk($sformatf("last[%0d]", k),  32'(out_last), (k == last_k) ? 32'd1 : 32'd0);
    chk($sformatf("done_hold[%0d]", k), 32'(done), 32'd0);
  endtask

  // Issue start from IDLE and check sample 0 appears exactly two edges later
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_raddr0", 32'(raddr), 32'd0);
    chk("start_valid_w1", 32'(out_valid), 32'd0);
    step();
    chk("start_valid_w2", 32'(out_valid), 32'd0);
    step();
    chk_sample(0, 3);
  endtask

  // From HOLD with out_ready=1: next sample k appears three edges later
  task automatic present(input int k);
    step();
    chk($sformatf("gap1[%0d]", k), 32'(out_valid), 32'd0);
    step();
    chk($sformatf("gap2[%0d]", k), 32'(out_valid), 32'd0);
    step();
    chk_sample(k, 3);
  endtask

  // Final sample accepted: one-cycle done pulse, back to IDLE
  task automatic finish_run();
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_last", 32'(out_last), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_raddr", 32'(raddr), 32'd3);
    chk("done_ib_kept", ib_out, 32'd13);
    chk("done_idx_kept", 32'(out_idx), 32'd3);
    step();
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    step();
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ib", ib_out, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_autostart", 32'(busy), 32'd0);

    // Normal stream, out_ready held high
    start_run();
    present(1);
    present(2);
    present(3);
    finish_run();

    // Backpressure on idx 2 for 5 cycles
    start_run();
    present(1);
    present(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_sample(2, 3);
    end
    out_ready = 1'b1;
    present(3);
    finish_run();

    // start while busy at idx 1 is ignored
    start_run();
    present(1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_raddr", 32'(raddr), 32'd2);
    chk("busy_start_valid", 32'(out_valid), 32'd0);
    step();
    chk("busy_start_gap", 32'(out_valid), 32'd0);
    step();
    chk_sample(2, 3);
    present(3);
    finish_run();

    // Abort during HOLD at idx 2 with out_ready=1
    start_run();
    present(1);
    present(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ib_kept", ib_out, 32'd12);
    chk("abort_idx_kept", 32'(out_idx), 32'd2);
    step();
    chk("abort_done_later", 32'(done), 32'd0);
    chk("abort_raddr_held", 32'(raddr), 32'd2);
    start_run();
    present(1);
    present(2);
    present(3);
    finish_run();

    // abort together with start in IDLE blocks the start
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_start", 32'(busy), 32'd0);

    // Async reset asserted between edges while in WAIT2
    start_run();
    present(1);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_raddr", 32'(raddr), 32'd0);
    chk("arst_ib", ib_out, 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
    end

    // Single-sample instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'd1);
    step();
    chk("n1_gap", 32'(out_valid1), 32'd0);
    step();
    chk("n1_valid", 32'(out_valid1), 32'd1);
    chk("n1_idx", 32'(out_idx1), 32'd0);
    chk("n1_last", 32'(out_last1), 32'd1);
    chk("n1_ib", ib_out1, 32'd10);
    step();
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_raddr", 32'(raddr1), 32'd0);
    chk("n1_idle", 32'(busy1), 32'd0);
    step();
    chk("n1_done_once", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
